// File: rtl/servo_capture_n.sv
// servo_capture_n: measures the high time of NCH asynchronous servo pulses and reads the results out over a scan chain.
// Latency: a width is captured 3 clk after the input pin falls (5 clk when GLITCH_FILTER_EN is defined).
// Backpressure: none; a new capture overwrites an unread one, and scan_en snapshots all channels and then shifts 1 bit/clk.
// Ports: clk (rising edge), rst (async, active high), in[NCH-1:0] pulse inputs,
//        scan_en / scan_in / scan_out serial readout; chain = NCH fields of {valid, ovf, count}, ch0 at the MSB end.
// Option: define GLITCH_FILTER_EN to add a 3-sample majority filter after each synchronizer.
module servo_capture_n #(
  parameter int NCH = 2,
  parameter int CW  = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in,
  input  logic           scan_en,
  input  logic           scan_in,
  output logic           scan_out
);

  localparam int FW = CW + 2;
  localparam int L  = NCH * FW;
  localparam logic [CW-1:0] CMAX = '1;

  // Number of clocks after reset before the (filtered) synchronized level is a
  // real sample of the pin instead of a reset value. Arming waits for it, so
  // a pin that is already high at reset release cannot look like a rising edge.
`ifdef GLITCH_FILTER_EN
  localparam int WARM = 5;
`else
  localparam int WARM = 2;
`endif

  logic [WARM-1:0] warm;
  logic            scan_en_d;
  logic            load;
  logic [L-1:0]    chain;
  logic [L-1:0]    load_vec;

  assign load = scan_en && !scan_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm      <= '0;
      scan_en_d <= 1'b0;
    end else begin
      warm      <= {warm[WARM-2:0], 1'b1};
      scan_en_d <= scan_en;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          sync1, sync2, sig, prev;
    logic          armed, active, rise, fall;
    logic [CW-1:0] cnt, cap_cnt;
    logic          ovf, cap_ovf, cap_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= in[i];
        sync2 <= sync1;
      end
    end

`ifdef GLITCH_FILTER_EN
    logic h1, h2, filt;
    // Majority of three consecutive samples; delays both edges equally so the width is preserved.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        h1   <= 1'b0;
        h2   <= 1'b0;
        filt <= 1'b0;
      end else begin
        h1   <= sync2;
        h2   <= h1;
        filt <= (sync2 & h1) | (sync2 & h2) | (h1 & h2);
      end
    end
    assign sig = filt;
`else
    assign sig = sync2;
`endif

    assign rise = armed && sig && !prev;
    // Only a pulse whose rising edge was counted may produce a capture.
    assign fall = active && prev && !sig;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev    <= 1'b0;
        armed   <= 1'b0;
        active  <= 1'b0;
        cnt     <= '0;
        ovf     <= 1'b0;
        cap_cnt <= '0;
        cap_ovf <= 1'b0;
        cap_vld <= 1'b0;
      end else begin
        prev <= sig;
        if (!armed && warm[WARM-1] && !sig)
          armed <= 1'b1;

        if (rise) begin
          cnt    <= CW'(1);
          ovf    <= 1'b0;
          active <= 1'b1;
        end else if (fall) begin
          active  <= 1'b0;
          cap_cnt <= cnt;
          cap_ovf <= ovf;
        end else if (active) begin
          if (cnt == CMAX)
            ovf <= 1'b1;
          else
            cnt <= cnt + CW'(1);
        end

        // A capture on the load cycle wins: the chain takes the old value, the new one stays valid.
        if (fall)
          cap_vld <= 1'b1;
        else if (load)
          cap_vld <= 1'b0;
      end
    end

    assign load_vec[L-1-i*FW -: FW] = {cap_vld, cap_ovf, cap_cnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      chain <= '0;
    else if (load)
      chain <= load_vec;
    else if (scan_en)
      chain <= {chain[L-2:0], scan_in};
  end

  assign scan_out = chain[L-1];

endmodule

// File: tb/tb_servo_capture_n.sv
// tb_servo_capture_n: directed pulses on the servo inputs, scan readout checked against a pulse-width model.
// Latency: model schedules each capture a fixed number of clocks after the pin falls.
// Backpressure: n/a.
module tb_servo_capture_n;

  localparam int NCH  = 2;
  localparam int CW   = 12;
  localparam int FW   = CW + 2;
  localparam int L    = NCH * FW;
  localparam int CMAX = (1 << CW) - 1;
`ifdef GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam int MINW = 2;
`else
  localparam int LAT  = 3;
  localparam int MINW = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] in = '0;
  logic           scan_en = 1'b0;
  logic           scan_in = 1'b0;
  logic           scan_out;

  servo_capture_n #(.NCH(NCH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int ch; int due; int w;} pend_t;
  pend_t pend[$];

  // Model: what each channel's capture register should hold, and the snapshot taken at scan start.
  int m_vld[NCH], m_ovf[NCH], m_cnt[NCH];
  int s_vld[NCH], s_ovf[NCH], s_cnt[NCH];
  // Fields decoded from the most recent complete scan of the DUT.
  int last_vld[NCH], last_ovf[NCH], last_cnt[NCH];

  logic [L-1:0] word;
  int           nbits = 0;
  bit           in_scan = 1'b0;
  bit           prev_scan = 1'b0;
  logic         hold_val = 1'b0;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Compare process: samples 1 time unit after every rising edge.
  always @(posedge clk) begin
    logic [FW-1:0] f;
    #1;
    cyc++;
    if (rst) begin
      chk("rst_scan_out", int'(scan_out), 0, 0);
      for (int c = 0; c < NCH; c++) begin
        m_vld[c] = 0; m_ovf[c] = 0; m_cnt[c] = 0;
      end
      pend.delete();
      prev_scan = 1'b0;
      in_scan   = 1'b0;
      hold_val  = 1'b0;
    end else begin
      if (scan_en && !prev_scan) begin
        for (int c = 0; c < NCH; c++) begin
          s_vld[c] = m_vld[c]; s_ovf[c] = m_ovf[c]; s_cnt[c] = m_cnt[c];
          m_vld[c] = 0;
        end
        nbits   = 0;
        in_scan = 1'b1;
      end
      for (int k = pend.size() - 1; k >= 0; k--) begin
        if (pend[k].due == cyc) begin
          m_vld[pend[k].ch] = 1;
          m_ovf[pend[k].ch] = (pend[k].w > CMAX) ? 1 : 0;
          m_cnt[pend[k].ch] = (pend[k].w > CMAX) ? CMAX : pend[k].w;
          pend.delete(k);
        end
      end
      if (scan_en && in_scan) begin
        word[L-1-nbits] = scan_out;
        hold_val = scan_out;
        nbits++;
        if (nbits == L) begin
          in_scan = 1'b0;
          for (int c = 0; c < NCH; c++) begin
            f = word[L-1-c*FW -: FW];
            last_vld[c] = int'(f[FW-1]);
            last_ovf[c] = int'(f[FW-2]);
            last_cnt[c] = int'(f[CW-1:0]);
            chk($sformatf("ch%0d_vld", c), last_vld[c], s_vld[c], s_vld[c]);
            chk($sformatf("ch%0d_ovf", c), last_ovf[c], s_ovf[c], s_ovf[c]);
            chk($sformatf("ch%0d_cnt", c), last_cnt[c], s_cnt[c] - 1, s_cnt[c] + 1);
          end
        end
      end else if (!scan_en) begin
        chk("hold", int'(scan_out), int'(hold_val), int'(hold_val));
      end
      prev_scan = scan_en;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // High for w clocks; the model expects a capture LAT clocks after the fall.
  task automatic pulse(input int ch, input int w);
    @(negedge clk);
    in[ch] = 1'b1;
    repeat (w) @(negedge clk);
    in[ch] = 1'b0;
    if (w >= MINW)
      pend.push_back('{ch, cyc + LAT, w});
  endtask

  // Called on a negedge: load edge plus L-1 shift edges, so exactly L bits are seen.
  task automatic scan();
    scan_in = ~scan_in;
    scan_en = 1'b1;
    repeat (L) @(negedge clk);
    scan_en = 1'b0;
    idle(3);
  endtask

  initial begin
    idle(10);
    rst = 1'b0;
    idle(5);

    // Reset state readout.
    scan();
    chk("lit_reset_vld0", last_vld[0], 0, 0);
    chk("lit_reset_cnt0", last_cnt[0], 0, 0);

    // Single 1835-cycle pulse.
    pulse(0, 1835);
    idle(LAT + 2);
    scan();
    chk("lit_1835_vld", last_vld[0], 1, 1);
    chk("lit_1835_ovf", last_ovf[0], 0, 0);
    chk("lit_1835_cnt", last_cnt[0], 1834, 1836);

    // Overlapping pulses; ch1 rises 1715 cycles into ch0's pulse.
    fork
      pulse(0, 1835);
      begin idle(1715); pulse(1, 240); end
    join
    idle(LAT + 2);
    scan();
    chk("lit_ovl_cnt0", last_cnt[0], 1834, 1836);
    chk("lit_ovl_cnt1", last_cnt[1], 239, 241);
    chk("lit_ovl_vld1", last_vld[1], 1, 1);

    // Simultaneous edges on both channels.
    idle(20);
    fork
      pulse(0, 700);
      pulse(1, 700);
    join
    idle(LAT + 2);
    scan();
    chk("lit_sim_cnt0", last_cnt[0], 699, 701);
    chk("lit_sim_cnt1", last_cnt[1], 699, 701);

    // Saturation, then a rescan with nothing new.
    idle(20);
    pulse(0, 5000);
    idle(LAT + 2);
    scan();
    chk("lit_sat_cnt", last_cnt[0], CMAX, CMAX);
    chk("lit_sat_ovf", last_ovf[0], 1, 1);
    chk("lit_sat_vld", last_vld[0], 1, 1);
    scan();
    chk("lit_rescan_vld", last_vld[0], 0, 0);
    chk("lit_rescan_cnt", last_cnt[0], CMAX, CMAX);
    chk("lit_rescan_ovf", last_ovf[0], 1, 1);

    // Reset 500 cycles into a 1500-cycle pulse: no capture from its fall.
    idle(5);
    in[0] = 1'b1;
    idle(500);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(997);
    in[0] = 1'b0;
    idle(20);
    scan();
    chk("lit_rstpulse_vld", last_vld[0], 0, 0);
    chk("lit_rstpulse_cnt", last_cnt[0], 0, 0);
    idle(20);
    pulse(0, 1000);
    idle(LAT + 2);
    scan();
    chk("lit_after_rst_cnt", last_cnt[0], 999, 1001);
    chk("lit_after_rst_vld", last_vld[0], 1, 1);

    // Capture landing on the load edge.
    idle(20);
    pulse(0, 300);
    idle(LAT + 2);
    pulse(0, 100);
    idle(LAT - 1);
    scan();
    chk("lit_coinc_old_cnt", last_cnt[0], 299, 301);
    chk("lit_coinc_old_vld", last_vld[0], 1, 1);
    scan();
    chk("lit_coinc_new_cnt", last_cnt[0], 99, 101);
    chk("lit_coinc_new_vld", last_vld[0], 1, 1);

    // One-cycle glitch on in[1].
    idle(20);
    pulse(1, 1);
    idle(LAT + 2);
    scan();
`ifdef GLITCH_FILTER_EN
    chk("lit_glitch_vld", last_vld[1], 0, 0);
`else
    chk("lit_glitch_vld", last_vld[1], 1, 1);
    chk("lit_glitch_cnt", last_cnt[1], 1, 1);
`endif

    // Reset in the middle of a scan, scan_en held: release gives a fresh load of cleared registers.
    idle(20);
    pulse(0, 50);
    idle(LAT + 2);
    scan_en = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(L);
    scan_en = 1'b0;
    idle(3);
    chk("lit_abort_vld", last_vld[0], 0, 0);
    chk("lit_abort_cnt", last_cnt[0], 0, 0);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
